tb_walk_controller: RTL
=======================

# tb_walk_controller

Sequencer for the traceback phase of the Needleman-Wunsch engine. On `start` it walks the direction matrix from cell (N,N) back to (0,0). At each interior cell it issues a read to the direction RAM, waits the fixed read latency, and decodes the returned symbol into the next cell. Each step is emitted as one alignment operation on a valid/ready stream toward the alignment-output builder. It sits between the score-fill controller (which raises `start`) and the direction RAM / output stage.

## Interface
Parameters:
- `N`, 128: sequence length; the matrix spans indices 0..N on both axes.
- `RD_LAT`, 2: direction-RAM read latency in cycles, ≥1.
- `BitAddr`, `$clog2(N+1)`: width of the `i`/`j` coordinates.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  single-cycle pulse that begins a traceback.
  - Sampled only in IDLE; ignored otherwise.
- `dir_rd_en`  out  1  direction-RAM read strobe, one cycle per read.
- `dir_addr_i`, `dir_addr_j`  out  BitAddr each  RAM row/column address, equal to i-1 / j-1.
- `dir_data`  in  3  direction symbol, valid exactly `RD_LAT` cycles after `dir_rd_en`.
  - Encoding: UP=3'b010, LEFT=3'b100, DIAG=3'b001.
- `op_valid`  out  1  alignment operation available.
- `op_ready`  in  1  consumer accepts the operation.
- `op_sym`  out  3  operation, using the same symbol encoding as `dir_data`.
- `op_i`, `op_j`  out  BitAddr each  cell the step leaves from.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the walk ends.
- `err`  out  1  sticky; set on an illegal symbol, cleared by the next accepted `start` or by `rst`.
- `steps`  out  BitAddr+1  count of accepted operations in the current walk (maximum 2N).

## Operation
- States: IDLE, ISSUE, WAIT, EMIT, FIN.
- IDLE, on `start`:
  - i←N, j←N, `steps`←0, `err`←0.
  - Go to ISSUE.
- ISSUE, one cycle:
  - If i≠0 and j≠0: assert `dir_rd_en` with the address (i-1, j-1), then go to WAIT.
  - If i=0 and j>0: load LEFT as the pending symbol without a RAM read, then go to EMIT.
  - If j=0 and i>0: load UP as the pending symbol without a RAM read, then go to EMIT.
- WAIT, `RD_LAT` cycles:
  - On the last WAIT cycle, capture `dir_data` into the pending symbol.
  - If the captured value is not one of the three legal codes: set `err` and go to FIN.
  - Otherwise go to EMIT.
- EMIT:
  - `op_valid`=1 with `op_sym`=pending symbol and `op_i`/`op_j`=current i/j.
  - All three outputs stay stable until `op_valid && op_ready`.
  - On handshake:
    - Update i/j: UP gives i-1; LEFT gives j-1; DIAG gives i-1 and j-1.
    - Increment `steps`.
    - If the new cell is (0,0), go to FIN; otherwise go to ISSUE.
- FIN: `done`=1 for one cycle, then go to IDLE.
- In IDLE, i/j/`steps`/`err` hold their last values for readout.
- Coordinates never underflow: a legal symbol never decrements an axis that is already 0. Interior cells take any legal symbol; boundary cells are forced.

## Timing
- Reset values:
  - State IDLE; i=j=0; `steps`=0.
  - `dir_rd_en`=0, `dir_addr_i`=`dir_addr_j`=0.
  - `op_valid`=0, `op_sym`=0, `op_i`=`op_j`=0.
  - `busy`=0, `done`=0, `err`=0.
- `busy` rises the cycle after `start` is sampled.
- Cost per step with `op_ready`=1:
  - Interior step: RD_LAT+2 cycles (ISSUE, WAIT×RD_LAT, EMIT).
  - Boundary step: 2 cycles (ISSUE, EMIT).
- `done` asserts the cycle after the final handshake. `busy` falls the cycle after `done`.
- `start` and `op_ready` are never combinationally routed to any output.
- `rst` mid-walk: immediate return to IDLE with all outputs at their reset values. A RAM read already in flight is discarded.
- `start` while `busy`=1 is ignored and leaves no pending request.

## Test plan
- N=4, RAM all DIAG, `op_ready`=1:
  - 4 ops (4,4),(3,3),(2,2),(1,1), all DIAG.
  - `steps`=4; `done` 17 cycles after `start` (4×(RD_LAT+2)+1).
- N=4, RAM returns UP at (4,4),(3,4),(2,4),(1,4):
  - 4 UP ops, then 4 forced LEFT ops at i=0 with no `dir_rd_en` asserted.
  - `steps`=8.
- Backpressure: hold `op_ready`=0 for 5 cycles on the second op.
  - `op_valid`, `op_sym`, `op_i`, `op_j` stay stable throughout.
  - Only one op is accepted when `op_ready` rises.
- Illegal symbol 3'b011 on the first read:
  - `err`=1, `done` pulses, no op emitted, `steps`=0.
  - `err` stays high until the next `start`.
- `rst` pulsed during WAIT of the third step:
  - All outputs go to reset values.
  - A following `start` yields a correct full walk.
- Second `start` during a walk: no effect on the sequence, `steps`, or `done` count (exactly one `done`).

Source files
------------

// File: rtl/tb_walk_controller.sv
// Traceback sequencer for the Needleman-Wunsch engine: walks the direction matrix
// from (N,N) to (0,0), reading interior cells and emitting one op per step.
module tb_walk_controller #(
  parameter int N       = 128,
  parameter int RD_LAT  = 2,
  parameter int BitAddr = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               dir_rd_en,
  output logic [BitAddr-1:0] dir_addr_i,
  output logic [BitAddr-1:0] dir_addr_j,
  input  logic [2:0]         dir_data,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [2:0]         op_sym,
  output logic [BitAddr-1:0] op_i,
  output logic [BitAddr-1:0] op_j,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [BitAddr:0]   steps
);

  localparam logic [2:0] SYM_UP   = 3'b010;
  localparam logic [2:0] SYM_LEFT = 3'b100;
  localparam logic [2:0] SYM_DIAG = 3'b001;

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0]      WLAST    = CW'(RD_LAT - 1);
  localparam logic [CW-1:0]      WONE     = CW'(1);
  localparam logic [BitAddr-1:0] AONE     = BitAddr'(1);
  localparam logic [BitAddr-1:0] ANMAX    = BitAddr'(N);
  localparam logic [BitAddr:0]   STEP_ONE = (BitAddr + 1)'(1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, FIN} state_t;

  state_t             state, state_nx;
  logic [BitAddr-1:0] i, j, i_nx, j_nx;
  logic [2:0]         sym;
  logic [CW-1:0]      wcnt;
  logic               rd_legal;

  assign rd_legal = (dir_data == SYM_UP) || (dir_data == SYM_LEFT) || (dir_data == SYM_DIAG);

  always_comb begin
    i_nx = i;
    j_nx = j;
    if (sym == SYM_UP || sym == SYM_DIAG)   i_nx = i - AONE;
    if (sym == SYM_LEFT || sym == SYM_DIAG) j_nx = j - AONE;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = ISSUE;
      ISSUE: begin
        if (i != '0 && j != '0)      state_nx = WAIT;
        else if (i == '0 && j == '0) state_nx = FIN;
        else                         state_nx = EMIT;
      end
      WAIT:  if (wcnt == WLAST) state_nx = rd_legal ? EMIT : FIN;
      EMIT: begin
        if (op_ready) state_nx = (i_nx == '0 && j_nx == '0) ? FIN : ISSUE;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      steps <= '0;
      err   <= 1'b0;
      sym   <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            i     <= ANMAX;
            j     <= ANMAX;
            steps <= '0;
            err   <= 1'b0;
          end
        end
        ISSUE: begin
          wcnt <= '0;
          // Boundary cells have a forced direction, so no RAM read is needed.
          if (i == '0)      sym <= SYM_LEFT;
          else if (j == '0) sym <= SYM_UP;
        end
        WAIT: begin
          wcnt <= wcnt + WONE;
          if (wcnt == WLAST) begin
            sym <= dir_data;
            if (!rd_legal) err <= 1'b1;
          end
        end
        EMIT: begin
          if (op_ready) begin
            i     <= i_nx;
            j     <= j_nx;
            steps <= steps + STEP_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign dir_rd_en  = (state == ISSUE) && (i != '0) && (j != '0);
  assign dir_addr_i = dir_rd_en ? i - AONE : '0;
  assign dir_addr_j = dir_rd_en ? j - AONE : '0;
  assign op_valid   = (state == EMIT);
  assign op_sym     = op_valid ? sym : '0;
  assign op_i       = op_valid ? i : '0;
  assign op_j       = op_valid ? j : '0;
  assign busy       = (state != IDLE);
  assign done       = (state == FIN);

endmodule
